snoop_bus_arbiter: RTL and testbench
====================================

Name: snoop_bus_arbiter

Overview:
- Owns the shared snooping bus between four processor-cache blocks.
- Round-robin arbitration of CPU requests; one owner per transaction.
- Per owned transaction: drives start to the owner and listen to every other processor, then collects the snooper responses.
- Sequences write-backs and memory reads, returns the combined 12-bit response word {wb, hit/valid, state[1:0], data[7:0]}, and pulses a completion to the owner.

Parameters:
- TIMEOUT, 15: maximum cycles waiting for mem_ack in WB or MEM before the transaction aborts (4-bit counter).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  4  per-processor request, level, held until done
- req_op  in  4  per-processor op (0 read, 1 write)
- req_block  in  8  2 bits per processor, processor i at [2i+1:2i]
- req_tag  in  20  5 bits per processor
- req_data  in  32  8 bits per processor, write data
- snoop_resp  in  48  12 bits per processor bus_out {wb, hit, state, data}
- mem_rdata  in  8  memory read data
- mem_ack  in  1  memory completion, one-cycle pulse
- grant  out  4  one-hot owner
- owner  out  2  owner index
- start  out  4  one-hot start to owner
- listen  out  4  listen to all non-owners
- op  out  1  latched op of owner
- block  out  2  latched block of owner
- tag  out  5  latched tag of owner
- wr_data  out  8  latched write data of owner
- bus_in  out  12  combined response word to all processors
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write-back, 0 = read
- mem_addr  out  7  {tag, block}
- mem_wdata  out  8  write-back data
- done  out  4  one-hot, one-cycle completion pulse to owner
- busy  out  1  high in any state except IDLE
- error  out  1  sticky timeout flag

Behaviour:
- Reset (reset=0, asynchronous) clears all outputs to 0, sets the FSM to IDLE, sets last_owner=3 so processor 0 wins first, clears the timeout counter and error. Reset mid-transaction aborts with no done pulse.
- IDLE: if any req bit is set, select the first set bit searching last_owner+1, +2, +3, +4 (mod 4). Latch that requester's op/block/tag/wr_data, assert grant/owner, go to ISSUE. No request: stay.
- ISSUE (1 cycle): start[owner]=1, listen = ~grant. Go to SNOOP.
- SNOOP (1 cycle): start/listen held. Evaluate non-owner responses; a snooper is a supplier if bit10=1 and state≠0. Choose the lowest-index supplier.
  - Supplier exists: bus_in = supplier word.
  - Supplier exists with wb=1: mem_wdata = supplier data, go to WB.
  - No supplier and op=0: go to MEM.
  - Otherwise: bus_in = 0, go to COMPLETE.
- WB: mem_req=1, mem_we=1, mem_addr={tag,block}. On mem_ack go to COMPLETE.
- MEM: mem_req=1, mem_we=0. On mem_ack set bus_in = {1'b0, 1'b1, 2'b00, mem_rdata} and go to COMPLETE.
- Timeout: the counter counts cycles spent in WB/MEM.
  - Reaching TIMEOUT without ack: error=1, bus_in[10]=0, go to COMPLETE.
  - mem_ack in the same cycle as the timeout: ack wins, no error.
- COMPLETE (1 cycle): done[owner]=1. start, listen, grant and mem_req drop to 0. bus_in holds until the next ISSUE. Set last_owner=owner, go to IDLE.
- req, op and data are sampled only in IDLE. Changes mid-transaction are ignored. Deasserting the owner's req mid-transaction does not abort.
- A requester still asserting req in IDLE after its done is eligible again but loses to any other pending requester.
- Latency from IDLE sample to done: 3 cycles without memory access; 4 + ack-wait cycles with WB or MEM.
- busy=0 only in IDLE. mem_req is never asserted outside WB/MEM.

Test Plan:
- Reset then req=4'b0001, op=0, no snooper hit: ISSUE start=0001, listen=1110; MEM with mem_addr={tag,block}; mem_ack with mem_rdata=8'h37 -> bus_in=12'h437, done=0001 one cycle later.
- Simultaneous req=4'b1111 held: grant order 0,1,2,3,0. Each done precedes the next grant by exactly one IDLE cycle.
- Owner 2 read; snooper 1 response {1,1,2'b10,8'h55}: WB with mem_we=1, mem_wdata=8'h55; ack -> bus_in=12'hE55, done=0100.
- Owner 0 write; snooper 3 response {0,1,2'b01,8'h32}: bus_in=12'h532, no mem_req, done at cycle 3.
- MEM with no ack for 15 cycles: error=1, bus_in[10]=0, done pulses. Repeat with ack at cycle 15: error stays 0.
- reset low during WB: mem_req, grant and busy go to 0 immediately, no done pulse; after release, req=0001 restarts from IDLE.

Source files
------------

// File: rtl/snoop_bus_arbiter_if.sv
// Signal bundle between the snoop bus arbiter, the four processor-cache blocks and memory.
// The master modport is the arbiter's view and the slave modport is the processor/memory view.
interface snoop_bus_arbiter_if;
   logic [3:0]  req;
   logic [3:0]  req_op;
   logic [7:0]  req_block;
   logic [19:0] req_tag;
   logic [31:0] req_data;
   logic [47:0] snoop_resp;
   logic [7:0]  mem_rdata;
   logic        mem_ack;

   logic [3:0]  grant;
   logic [1:0]  owner;
   logic [3:0]  start;
   logic [3:0]  listen;
   logic        op;
   logic [1:0]  block;
   logic [4:0]  tag;
   logic [7:0]  wr_data;
   logic [11:0] bus_in;
   logic        mem_req;
   logic        mem_we;
   logic [6:0]  mem_addr;
   logic [7:0]  mem_wdata;
   logic [3:0]  done;
   logic        busy;
   logic        error;

   modport master (
      input  req, req_op, req_block, req_tag, req_data, snoop_resp, mem_rdata, mem_ack,
      output grant, owner, start, listen, op, block, tag, wr_data, bus_in,
             mem_req, mem_we, mem_addr, mem_wdata, done, busy, error
   );

   modport slave (
      output req, req_op, req_block, req_tag, req_data, snoop_resp, mem_rdata, mem_ack,
      input  grant, owner, start, listen, op, block, tag, wr_data, bus_in,
             mem_req, mem_we, mem_addr, mem_wdata, done, busy, error
   );
endinterface

// File: rtl/snoop_bus_arbiter.sv
// Round-robin owner of the shared snooping bus: issues a transaction, gathers snooper
// responses, sequences a write-back or memory read, and returns the combined response word.
module snoop_bus_arbiter #(
   parameter int TIMEOUT = 15
) (
   input  logic                 clock,
   input  logic                 reset,
   snoop_bus_arbiter_if.master  bus
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      SNOOP,
      WB,
      MEM,
      COMPLETE
   } state_t;

   state_t      state;
   state_t      next_state;

   logic [1:0]  owner_q;
   logic [1:0]  last_owner;
   logic        op_q;
   logic [1:0]  block_q;
   logic [4:0]  tag_q;
   logic [7:0]  wr_data_q;
   logic [7:0]  mem_wdata_q;
   logic [11:0] bus_in_q;
   logic [3:0]  timer;
   logic        error_q;

   logic [1:0]  winner;
   logic        winner_found;
   logic [11:0] supplier_word;
   logic        supplier_found;
   logic        timed_out;
   logic [3:0]  owner_vec;

   logic [3:0]  grant_c;
   logic [3:0]  start_c;
   logic [3:0]  listen_c;
   logic [3:0]  done_c;
   logic        mem_req_c;
   logic        mem_we_c;

   assign owner_vec = 4'b0001 << owner_q;
   assign timed_out = (timer == 4'(TIMEOUT - 1));

   // Scan downward so the requester closest after last_owner is the one left standing.
   always_comb begin
      winner       = 2'd0;
      winner_found = 1'b0;
      for (int k = 4; k >= 1; k--) begin
         if (bus.req[last_owner + 2'(k)]) begin
            winner       = last_owner + 2'(k);
            winner_found = 1'b1;
         end
      end
   end

   // A snooper supplies the line when it hits with a non-invalid state; lowest index wins.
   always_comb begin
      supplier_word  = 12'h000;
      supplier_found = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if ((2'(i) != owner_q) && bus.snoop_resp[12*i + 10] &&
             (bus.snoop_resp[12*i + 8 +: 2] != 2'b00)) begin
            supplier_word  = bus.snoop_resp[12*i +: 12];
            supplier_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:     if (winner_found) next_state = ISSUE;
         ISSUE:    next_state = SNOOP;
         SNOOP: begin
            if (supplier_found && supplier_word[11]) begin
               next_state = WB;
            end else if (!supplier_found && !op_q) begin
               next_state = MEM;
            end else begin
               next_state = COMPLETE;
            end
         end
         WB, MEM:  if (bus.mem_ack || timed_out) next_state = COMPLETE;
         COMPLETE: next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   // An ack arriving in the timeout cycle takes priority, so the timeout branch sits under it.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         owner_q     <= 2'd0;
         last_owner  <= 2'd3;
         op_q        <= 1'b0;
         block_q     <= 2'd0;
         tag_q       <= 5'd0;
         wr_data_q   <= 8'h00;
         mem_wdata_q <= 8'h00;
         bus_in_q    <= 12'h000;
         timer       <= 4'd0;
         error_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (winner_found) begin
                  owner_q   <= winner;
                  op_q      <= bus.req_op[winner];
                  block_q   <= bus.req_block[2*winner +: 2];
                  tag_q     <= bus.req_tag[5*winner +: 5];
                  wr_data_q <= bus.req_data[8*winner +: 8];
               end
            end
            ISSUE: bus_in_q <= 12'h000;
            SNOOP: begin
               timer <= 4'd0;
               if (supplier_found) begin
                  bus_in_q <= supplier_word;
                  if (supplier_word[11]) mem_wdata_q <= supplier_word[7:0];
               end
            end
            WB, MEM: begin
               if (bus.mem_ack) begin
                  if (state == MEM) bus_in_q <= {4'b0100, bus.mem_rdata};
               end else if (timed_out) begin
                  error_q      <= 1'b1;
                  bus_in_q[10] <= 1'b0;
               end else begin
                  timer <= timer + 4'd1;
               end
            end
            COMPLETE: last_owner <= owner_q;
            default: ;
         endcase
      end
   end

   always_comb begin
      grant_c   = 4'b0000;
      start_c   = 4'b0000;
      listen_c  = 4'b0000;
      done_c    = 4'b0000;
      mem_req_c = 1'b0;
      mem_we_c  = 1'b0;
      case (state)
         ISSUE, SNOOP: begin
            grant_c  = owner_vec;
            start_c  = owner_vec;
            listen_c = ~owner_vec;
         end
         WB: begin
            grant_c   = owner_vec;
            start_c   = owner_vec;
            listen_c  = ~owner_vec;
            mem_req_c = 1'b1;
            mem_we_c  = 1'b1;
         end
         MEM: begin
            grant_c   = owner_vec;
            start_c   = owner_vec;
            listen_c  = ~owner_vec;
            mem_req_c = 1'b1;
         end
         COMPLETE: done_c = owner_vec;
         default: ;
      endcase
   end

   assign bus.grant     = grant_c;
   assign bus.owner     = owner_q;
   assign bus.start     = start_c;
   assign bus.listen    = listen_c;
   assign bus.op        = op_q;
   assign bus.block     = block_q;
   assign bus.tag       = tag_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.bus_in    = bus_in_q;
   assign bus.mem_req   = mem_req_c;
   assign bus.mem_we    = mem_we_c;
   assign bus.mem_addr  = mem_req_c ? {tag_q, block_q} : 7'd0;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.done      = done_c;
   assign bus.busy      = (state != IDLE);
   assign bus.error     = error_q;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter: the stimulus thread queues expected completions,
// and a negedge monitor pops and compares them whenever a done pulse appears.
module tb_snoop_bus_arbiter;

   typedef struct {
      logic [3:0]  done;
      logic [11:0] bus_in;
      logic        error;
   } expect_t;

   logic    clock;
   logic    reset;
   int      checks   = 0;
   int      failures = 0;
   expect_t sb_queue[$];

   snoop_bus_arbiter_if bus_if ();

   snoop_bus_arbiter #(.TIMEOUT(15)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] req, input logic [3:0] op, input logic [7:0] blk,
                                input logic [19:0] tg, input logic [31:0] dat, input logic [47:0] snp);
      bus_if.req        = req;
      bus_if.req_op     = op;
      bus_if.req_block  = blk;
      bus_if.req_tag    = tg;
      bus_if.req_data   = dat;
      bus_if.snoop_resp = snp;
   endtask

   task automatic expectDone(input logic [3:0] d, input logic [11:0] b, input logic e);
      expect_t item;
      item.done   = d;
      item.bus_in = b;
      item.error  = e;
      sb_queue.push_back(item);
   endtask

   task automatic pulseAck(input logic [7:0] rdata);
      bus_if.mem_ack   = 1'b1;
      bus_if.mem_rdata = rdata;
      @(negedge clock);
      bus_if.mem_ack   = 1'b0;
   endtask

   task automatic waitDone(input int max_cycles);
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (bus_if.done == 4'b0000 && n < max_cycles);
      if (bus_if.done == 4'b0000) begin
         checks++;
         failures++;
         $display("[TB] FAIL done_timeout actual=none required=done within %0d cycles", max_cycles);
      end
   endtask

   task automatic doReset();
      reset = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
   endtask

   // Every done pulse must match the oldest queued expectation.
   always @(negedge clock) begin
      if (bus_if.done != 4'b0000) begin
         if (sb_queue.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_done actual=%0h required=no pulse", bus_if.done);
         end else begin
            expect_t item;
            item = sb_queue.pop_front();
            checkOutput("sb_done", 32'(bus_if.done), 32'(item.done));
            checkOutput("sb_bus_in", 32'(bus_if.bus_in), 32'(item.bus_in));
            checkOutput("sb_error", 32'(bus_if.error), 32'(item.error));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [3:0] grant_order [5];
      grant_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

      reset            = 1'b0;
      bus_if.mem_ack   = 1'b0;
      bus_if.mem_rdata = 8'h00;
      applyStimulus(4'b0000, 4'b0000, 8'h00, 20'h0, 32'h0, 48'h0);
      @(negedge clock);
      @(negedge clock);
      checkOutput("rst_grant", 32'(bus_if.grant), 32'h0);
      checkOutput("rst_busy", 32'(bus_if.busy), 32'h0);
      checkOutput("rst_bus_in", 32'(bus_if.bus_in), 32'h0);
      checkOutput("rst_error", 32'(bus_if.error), 32'h0);
      checkOutput("rst_mem_req", 32'(bus_if.mem_req), 32'h0);
      checkOutput("rst_start", 32'(bus_if.start), 32'h0);
      reset = 1'b1;

      // Plain read miss from processor 0, served by memory.
      applyStimulus(4'b0001, 4'b0000, 8'h02, 20'h00013, 32'h0, 48'h0);
      expectDone(4'b0001, 12'h437, 1'b0);
      @(negedge clock);
      checkOutput("t1_start", 32'(bus_if.start), 32'h1);
      checkOutput("t1_listen", 32'(bus_if.listen), 32'hE);
      checkOutput("t1_busy", 32'(bus_if.busy), 32'h1);
      @(negedge clock);
      @(negedge clock);
      checkOutput("t1_mem_req", 32'(bus_if.mem_req), 32'h1);
      checkOutput("t1_mem_we", 32'(bus_if.mem_we), 32'h0);
      checkOutput("t1_mem_addr", 32'(bus_if.mem_addr), 32'h4E);
      pulseAck(8'h37);
      checkOutput("t1_done_now", 32'(bus_if.done), 32'h1);
      bus_if.req = 4'b0000;
      @(negedge clock);

      // All four requesting: rotation from a fresh reset.
      doReset();
      for (int k = 0; k < 5; k++) expectDone(grant_order[k], 12'h000, 1'b0);
      applyStimulus(4'b1111, 4'b1111, 8'h00, 20'h0, 32'h0, 48'h0);
      @(negedge clock);
      for (int k = 0; k < 5; k++) begin
         checkOutput("t2_grant", 32'(bus_if.grant), 32'(grant_order[k]));
         waitDone(8);
         if (k == 4) bus_if.req = 4'b0000;
         @(negedge clock);
         checkOutput("t2_idle_gap", 32'(bus_if.busy), 32'h0);
         if (k < 4) @(negedge clock);
      end

      // Owner 2 read hits dirty in snooper 1; owner's own and an invalid hit are ignored.
      applyStimulus(4'b0100, 4'b0000, 8'h10, 20'h02800, 32'h0, 48'h4AA_F11_E55_000);
      expectDone(4'b0100, 12'hE55, 1'b0);
      @(negedge clock);
      checkOutput("t3_start", 32'(bus_if.start), 32'h4);
      checkOutput("t3_listen", 32'(bus_if.listen), 32'hB);
      @(negedge clock);
      @(negedge clock);
      checkOutput("t3_mem_req", 32'(bus_if.mem_req), 32'h1);
      checkOutput("t3_mem_we", 32'(bus_if.mem_we), 32'h1);
      checkOutput("t3_mem_wdata", 32'(bus_if.mem_wdata), 32'h55);
      checkOutput("t3_mem_addr", 32'(bus_if.mem_addr), 32'h29);
      @(negedge clock);
      pulseAck(8'h00);
      bus_if.req = 4'b0000;
      @(negedge clock);

      // Owner 0 write, clean supplier 3: no memory traffic, done in the third cycle.
      applyStimulus(4'b0001, 4'b0001, 8'h03, 20'h00007, 32'h000000C3, 48'h532_000_000_000);
      expectDone(4'b0001, 12'h532, 1'b0);
      @(negedge clock);
      checkOutput("t4_op", 32'(bus_if.op), 32'h1);
      checkOutput("t4_tag", 32'(bus_if.tag), 32'h07);
      checkOutput("t4_block", 32'(bus_if.block), 32'h3);
      checkOutput("t4_wr_data", 32'(bus_if.wr_data), 32'hC3);
      @(negedge clock);
      checkOutput("t4_no_mem_req", 32'(bus_if.mem_req), 32'h0);
      @(negedge clock);
      checkOutput("t4_latency", 32'(bus_if.done), 32'h1);
      checkOutput("t4_no_mem_req_end", 32'(bus_if.mem_req), 32'h0);
      bus_if.req = 4'b0000;
      @(negedge clock);

      // Memory read with no ack: aborts after the fifteenth waiting cycle.
      applyStimulus(4'b0010, 4'b0000, 8'h00, 20'h0, 32'h0, 48'h0);
      expectDone(4'b0010, 12'h000, 1'b1);
      @(negedge clock);
      @(negedge clock);
      @(negedge clock);
      repeat (14) @(negedge clock);
      checkOutput("t5_still_mem", 32'(bus_if.mem_req), 32'h1);
      checkOutput("t5_no_error_yet", 32'(bus_if.error), 32'h0);
      @(negedge clock);
      bus_if.req = 4'b0000;
      @(negedge clock);
      checkOutput("t5_error_sticky", 32'(bus_if.error), 32'h1);
      checkOutput("t5_bus_in_hit", 32'(bus_if.bus_in[10]), 32'h0);
      doReset();
      checkOutput("t5_error_cleared", 32'(bus_if.error), 32'h0);

      // Ack in the very cycle the timeout would fire: ack wins.
      applyStimulus(4'b0001, 4'b0000, 8'h00, 20'h0, 32'h0, 48'h0);
      expectDone(4'b0001, 12'h49C, 1'b0);
      @(negedge clock);
      @(negedge clock);
      @(negedge clock);
      repeat (14) @(negedge clock);
      checkOutput("t5b_still_mem", 32'(bus_if.mem_req), 32'h1);
      pulseAck(8'h9C);
      bus_if.req = 4'b0000;
      @(negedge clock);
      checkOutput("t5b_no_error", 32'(bus_if.error), 32'h0);

      // Reset asserted during a write-back aborts silently; the request then restarts.
      applyStimulus(4'b0001, 4'b0000, 8'h00, 20'h0001F, 32'h0, 48'h000_000_E55_000);
      @(negedge clock);
      @(negedge clock);
      @(negedge clock);
      checkOutput("t6_in_wb", 32'(bus_if.mem_req), 32'h1);
      checkOutput("t6_mem_addr", 32'(bus_if.mem_addr), 32'h7C);
      #2 reset = 1'b0;
      #1;
      checkOutput("t6_rst_mem_req", 32'(bus_if.mem_req), 32'h0);
      checkOutput("t6_rst_grant", 32'(bus_if.grant), 32'h0);
      checkOutput("t6_rst_busy", 32'(bus_if.busy), 32'h0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      expectDone(4'b0001, 12'hE55, 1'b0);
      @(negedge clock);
      checkOutput("t6_regrant", 32'(bus_if.grant), 32'h1);
      checkOutput("t6_restart", 32'(bus_if.start), 32'h1);
      @(negedge clock);
      @(negedge clock);
      pulseAck(8'h00);
      bus_if.req = 4'b0000;
      repeat (3) @(negedge clock);

      checkOutput("sb_drained", 32'(sb_queue.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
